grant_index_arbiter: RTL and testbench



---
 rtl/grant_index_arbiter.sv | 151 +++++++++++++++
 tb/tb_grant_index_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/grant_index_arbiter.sv
// grant_index_arbiter
//   Eight-requester arbiter that picks one active request and presents the
//   winner as a registered 3-bit index. The index feeds the select input of
//   the downstream 3-to-8 decoder. Each grant is held until it is released or
//   until the hold limit expires. A single GAP cycle follows every grant.
//
//   Build option:
//     ARB_RR_EN defined   - round-robin search starting at ptr; ptr moves past
//                           each released winner.
//     ARB_RR_EN undefined - fixed priority; the lowest set request bit wins.
//
//   Parameters:
//     MAX_HOLD - maximum number of cycles gnt_vld stays high for one grant
//                (1 .. 2**CNT_W-1)
//     CNT_W    - width of the hold counter
//
//   Ports:
//     clk     in   1  rising-edge clock
//     rst     in   1  asynchronous active-high reset
//     req     in   8  request vector, bit i = requester i
//     done    in   1  release strobe from the current owner (GRANT only)
//     gnt_idx out  3  registered winner index
//     gnt_vld out  1  gnt_idx holds a valid grant
//     timeout out  1  high during the GAP cycle that follows a forced release
module grant_index_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx_nxt;
  logic             vld_nxt;
  logic             to_nxt;
  logic             release_now;

  // Starting point of the arbitration search
  logic [2:0]       base;

`ifdef ARB_RR_EN
  logic [2:0] ptr, ptr_nxt;
  assign base = ptr;
`else
  assign base = '0;
`endif

  // Winner: first set request bit searching upward from base, wrapping 7 to 0.
  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = base + 3'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = gnt_idx;
    vld_nxt     = gnt_vld;
    to_nxt      = timeout;
    release_now = 1'b0;
`ifdef ARB_RR_EN
    ptr_nxt     = ptr;
`endif
    case (state)
      IDLE: begin
        vld_nxt = 1'b0;
        if (|req) begin
          idx_nxt   = winner;
          vld_nxt   = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Owner release takes precedence over the hold limit
        if (done || !req[gnt_idx]) begin
          release_now = 1'b1;
        end else if (cnt == CNT_W'(MAX_HOLD)) begin
          release_now = 1'b1;
          to_nxt      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (release_now) begin
          state_nxt = GAP;
          vld_nxt   = 1'b0;
`ifdef ARB_RR_EN
          ptr_nxt   = gnt_idx + 3'd1;
`endif
        end
      end
      GAP: begin
        to_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        to_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
`ifdef ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
      timeout <= to_nxt;
`ifdef ARB_RR_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_grant_index_arbiter.sv
// tb_grant_index_arbiter
//   Directed-vector bench for grant_index_arbiter with MAX_HOLD=15, CNT_W=4.
//   Expected winners differ between round-robin (ARB_RR_EN) and fixed priority.
module tb_grant_index_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_checks;
  int n_fail;

  int exp_seq[5];
  int drop_exp;
  int wrap2_exp;

  grant_index_arbiter #(
    .MAX_HOLD(15),
    .CNT_W   (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef ARB_RR_EN
    exp_seq   = '{0, 2, 7, 0, 2};
    drop_exp  = 2;
    wrap2_exp = 5;
`else
    exp_seq   = '{0, 0, 0, 0, 0};
    drop_exp  = 1;
    wrap2_exp = 0;
`endif

    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    #2;
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_to",  32'(timeout), 32'd0);
    tick;
    tick;
    rst = 1'b0;

    // Arbitration order with req=0x85 held, one-cycle done per grant
    req = 8'h85;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("seq_vld", 32'(gnt_vld), 32'd1);
      check("seq_idx", 32'(gnt_idx), 32'(exp_seq[k]));
      done = 1'b1;
      tick;
      check("seq_gap_vld", 32'(gnt_vld), 32'd0);
      check("seq_gap_idx", 32'(gnt_idx), 32'(exp_seq[k]));
      check("seq_gap_to",  32'(timeout), 32'd0);
      done = 1'b0;
      tick;
      check("seq_idle_vld", 32'(gnt_vld), 32'd0);
    end
    req = 8'h00;

    // Forced release after 15 cycles, then re-grant to index 3
    req = 8'h08;
    tick;
    check("to_first_vld", 32'(gnt_vld), 32'd1);
    check("to_first_idx", 32'(gnt_idx), 32'd3);
    for (int k = 1; k < 15; k++) begin
      tick;
      check("to_hold_vld", 32'(gnt_vld), 32'd1);
      check("to_hold_idx", 32'(gnt_idx), 32'd3);
      check("to_hold_to",  32'(timeout), 32'd0);
    end
    tick;
    check("to_gap_vld", 32'(gnt_vld), 32'd0);
    check("to_gap_to",  32'(timeout), 32'd1);
    check("to_gap_idx", 32'(gnt_idx), 32'd3);
    tick;
    check("to_idle_vld", 32'(gnt_vld), 32'd0);
    check("to_idle_to",  32'(timeout), 32'd0);
    tick;
    check("to_regrant_vld", 32'(gnt_vld), 32'd1);
    check("to_regrant_idx", 32'(gnt_idx), 32'd3);

    // done on the same edge that reaches the hold limit: normal release
    for (int k = 1; k < 15; k++) begin
      tick;
      check("sim_hold_vld", 32'(gnt_vld), 32'd1);
    end
    done = 1'b1;
    tick;
    check("sim_rel_vld", 32'(gnt_vld), 32'd0);
    check("sim_rel_to",  32'(timeout), 32'd0);
    done = 1'b0;
    tick;
    check("sim_idle_to",  32'(timeout), 32'd0);
    check("sim_idle_vld", 32'(gnt_vld), 32'd0);
    req = 8'h00;

    // Request drop mid-grant; req seen during GAP must be ignored
    req = 8'h02;
    tick;
    check("drop_vld", 32'(gnt_vld), 32'd1);
    check("drop_idx", 32'(gnt_idx), 32'd1);
    tick;
    check("drop_hold_vld", 32'(gnt_vld), 32'd1);
    req = 8'h00;
    tick;
    check("drop_rel_vld", 32'(gnt_vld), 32'd0);
    check("drop_rel_to",  32'(timeout), 32'd0);
    check("drop_rel_idx", 32'(gnt_idx), 32'd1);
    req = 8'h06;
    tick;
    check("drop_gapign_vld", 32'(gnt_vld), 32'd0);
    tick;
    check("drop_next_vld", 32'(gnt_vld), 32'd1);
    check("drop_next_idx", 32'(gnt_idx), 32'(drop_exp));
    done = 1'b1;
    tick;
    check("drop_done_vld", 32'(gnt_vld), 32'd0);
    done = 1'b0;
    req  = 8'h00;
    tick;
    check("drop_idle_vld", 32'(gnt_vld), 32'd0);

    // Asynchronous reset in the middle of a grant to index 5
    req = 8'h20;
    tick;
    check("rstg_vld", 32'(gnt_vld), 32'd1);
    check("rstg_idx", 32'(gnt_idx), 32'd5);
    tick;
    check("rstg_hold_vld", 32'(gnt_vld), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstg_async_vld", 32'(gnt_vld), 32'd0);
    check("rstg_async_idx", 32'(gnt_idx), 32'd0);
    check("rstg_async_to",  32'(timeout), 32'd0);
    tick;
    rst = 1'b0;
    check("rstg_held_vld", 32'(gnt_vld), 32'd0);
    tick;
    check("rstg_regrant_vld", 32'(gnt_vld), 32'd1);
    check("rstg_regrant_idx", 32'(gnt_idx), 32'd5);

    // Wrap-around search: after winner 5, req=0x21 yields 0, then 5 (rr)
    done = 1'b1;
    tick;
    check("wrap_rel_vld", 32'(gnt_vld), 32'd0);
    done = 1'b0;
    req  = 8'h21;
    tick;
    check("wrap_idle_vld", 32'(gnt_vld), 32'd0);
    tick;
    check("wrap_vld", 32'(gnt_vld), 32'd1);
    check("wrap_idx", 32'(gnt_idx), 32'd0);
    done = 1'b1;
    tick;
    done = 1'b0;
    check("wrap2_gap_vld", 32'(gnt_vld), 32'd0);
    tick;
    tick;
    check("wrap2_vld", 32'(gnt_vld), 32'd1);
    check("wrap2_idx", 32'(gnt_idx), 32'(wrap2_exp));
    req = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
